// File: rtl/sd_cmd_pkg.sv
// Shared constants and types for the card-side SD command responder.
package sd_cmd_pkg;

    localparam int FRAME_W = 40;
    localparam int ARG_W   = 32;
    localparam int IDX_W   = 6;

    localparam int START_HI = 39;
    localparam int START_LO = 38;
    localparam int IDX_HI   = 37;
    localparam int IDX_LO   = 32;
    localparam int ARG_HI   = 31;
    localparam int ARG_LO   = 0;

    localparam logic [1:0] START_HOST = 2'b01;
    localparam logic [1:0] START_CARD = 2'b00;

    localparam logic [IDX_W-1:0] CMD_GO_IDLE = 6'd0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_WAIT_NCR = 2'd2,
        ST_SEND     = 2'd3
    } state_t;

    function automatic logic [FRAME_W-1:0] make_resp(
        input logic [IDX_W-1:0] idx,
        input logic [ARG_W-1:0] arg
    );
        return {START_CARD, idx, arg};
    endfunction

endpackage

// File: rtl/sd_cmd_responder.sv
// Card-side SD command endpoint: accepts host frames, dispatches them to
// the application and returns a response frame after the Ncr delay.
module sd_cmd_responder
    import sd_cmd_pkg::*;
#(
    parameter int RESP_DELAY   = 2,
    parameter int RESP_TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               strobe_in,
    input  logic [FRAME_W-1:0] cmd_in,
    input  logic               ack_in,
    input  logic               resp_valid,
    input  logic [ARG_W-1:0]   resp_argument,
    output logic               ack_out,
    output logic               strobe_out,
    output logic [FRAME_W-1:0] resp_out,
    output logic               cmd_valid,
    output logic [IDX_W-1:0]   cmd_index,
    output logic [ARG_W-1:0]   cmd_argument,
    output logic               busy,
    output logic               idle_out,
    output logic               frame_error,
    output logic               resp_timeout
);

    localparam logic [3:0]  DELAY_LD    = 4'(RESP_DELAY);
    localparam logic [31:0] TIMEOUT_LIM = 32'(RESP_TIMEOUT);

    state_t state_q, state_n;

    logic [31:0]        wait_q, wait_n;
    logic [3:0]         dly_q, dly_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [ARG_W-1:0]   arg_q, arg_n;
    logic [FRAME_W-1:0] resp_q, resp_n;

    logic ack_q, ack_n;
    logic cmdv_q, cmdv_n;
    logic strb_q, strb_n;
    logic ferr_q, ferr_n;
    logic tout_q, tout_n;
    logic busy_q, idle_q;

    always_comb begin
        state_n = state_q;
        wait_n  = wait_q;
        dly_n   = dly_q;
        idx_n   = idx_q;
        arg_n   = arg_q;
        resp_n  = resp_q;
        ack_n   = 1'b0;
        cmdv_n  = 1'b0;
        strb_n  = 1'b0;
        ferr_n  = 1'b0;
        tout_n  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (strobe_in) begin
                    if (cmd_in[START_HI:START_LO] == START_HOST) begin
                        idx_n   = cmd_in[IDX_HI:IDX_LO];
                        arg_n   = cmd_in[ARG_HI:ARG_LO];
                        wait_n  = 32'd0;
                        ack_n   = 1'b1;
                        cmdv_n  = 1'b1;
                        state_n = ST_DISPATCH;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end
            end
            ST_DISPATCH: begin
                // GO_IDLE gets a one-cycle cmd_valid and no response frame
                if (idx_q == CMD_GO_IDLE) begin
                    state_n = ST_IDLE;
                end else if (resp_valid) begin
                    resp_n = make_resp(idx_q, resp_argument);
                    dly_n  = DELAY_LD;
                    if (DELAY_LD == 4'd0) begin
                        strb_n  = 1'b1;
                        state_n = ST_SEND;
                    end else begin
                        state_n = ST_WAIT_NCR;
                    end
                end else if (wait_q + 32'd1 == TIMEOUT_LIM) begin
                    wait_n  = wait_q + 32'd1;
                    tout_n  = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    wait_n = wait_q + 32'd1;
                    cmdv_n = 1'b1;
                end
            end
            ST_WAIT_NCR: begin
                dly_n = dly_q - 4'd1;
                if (dly_q == 4'd1) begin
                    strb_n  = 1'b1;
                    state_n = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ack_in) begin
                    state_n = ST_IDLE;
                end else begin
                    strb_n = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            dly_q   <= '0;
            idx_q   <= '0;
            arg_q   <= '0;
            resp_q  <= '0;
            ack_q   <= 1'b0;
            cmdv_q  <= 1'b0;
            strb_q  <= 1'b0;
            ferr_q  <= 1'b0;
            tout_q  <= 1'b0;
            busy_q  <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_n;
            wait_q  <= wait_n;
            dly_q   <= dly_n;
            idx_q   <= idx_n;
            arg_q   <= arg_n;
            resp_q  <= resp_n;
            ack_q   <= ack_n;
            cmdv_q  <= cmdv_n;
            strb_q  <= strb_n;
            ferr_q  <= ferr_n;
            tout_q  <= tout_n;
            busy_q  <= (state_n != ST_IDLE);
            idle_q  <= (state_n == ST_IDLE);
        end
    end

    assign ack_out      = ack_q;
    assign strobe_out   = strb_q;
    assign resp_out     = resp_q;
    assign cmd_valid    = cmdv_q;
    assign cmd_index    = idx_q;
    assign cmd_argument = arg_q;
    assign busy         = busy_q;
    assign idle_out     = idle_q;
    assign frame_error  = ferr_q;
    assign resp_timeout = tout_q;

endmodule
